// File: rtl/mdclcg_pkg.sv
// Shared widths and types for the MDCLCG datapath.
// Used by the pipelined right shifter.
package mdclcg_pkg;

  localparam int DATA_W = 64;
  localparam int SHW    = 6;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [SHW-1:0]    shamt_t;

endpackage

// File: rtl/rshift_stage.sv
// One log-stage of the right shifter: conditional shift
// by 2**STEP with sign/zero fill, plus its hold register.
module rshift_stage
  import mdclcg_pkg::*;
#(
  parameter int STEP = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic [SHW-1:0]    i_shift,
  input  logic              i_arith,
  input  logic              i_sgn,
  input  logic              i_rdy_next,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [SHW-1:0]    o_shift,
  output logic              o_arith,
  output logic              o_sgn
);

  localparam int S = 1 << STEP;

  logic   r_valid;
  word_t  r_data;
  shamt_t r_shift;
  logic   r_arith;
  logic   r_sgn;

  logic   w_rdy;
  logic   w_load;
  logic   w_fill;
  word_t  w_shifted;
  word_t  w_next;

  assign w_rdy     = !r_valid | i_rdy_next;
  assign w_load    = i_valid & w_rdy;
  assign w_fill    = i_arith & i_sgn;
  assign w_shifted = {{S{w_fill}}, i_data[DATA_W-1:S]};
  assign w_next    = i_shift[STEP] ? w_shifted : i_data;

  // Payload only moves on a real transfer; valid follows rdy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_shift <= '0;
      r_arith <= 1'b0;
      r_sgn   <= 1'b0;
    end else begin
      if (w_rdy)
        r_valid <= i_valid;
      if (w_load) begin
        r_data  <= w_next;
        r_shift <= i_shift;
        r_arith <= i_arith;
        r_sgn   <= i_sgn;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_shift = r_shift;
  assign o_arith = r_arith;
  assign o_sgn   = r_sgn;

endmodule

// File: rtl/rshift_pipe.sv
// Six-stage pipelined 64-bit right shifter, logical or
// arithmetic, with valid/ready on both sides.
module rshift_pipe
  import mdclcg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SHW-1:0]    in_shift,
  input  logic              in_arith,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic   w_v   [0:SHW];
  word_t  w_d   [0:SHW];
  shamt_t w_sh  [0:SHW];
  logic   w_ar  [0:SHW];
  logic   w_sgn [0:SHW];
  logic [SHW:0] w_rdy;

  assign w_v[0]   = in_valid;
  assign w_d[0]   = in_data;
  assign w_sh[0]  = in_shift;
  assign w_ar[0]  = in_arith;
  assign w_sgn[0] = in_data[DATA_W-1];

  // Per-stage ready so bubbles anywhere collapse.
  always_comb begin
    w_rdy[SHW] = out_ready;
    for (int k = SHW - 1; k >= 0; k--)
      w_rdy[k] = !w_v[k+1] | w_rdy[k+1];
  end

  for (genvar g = 0; g < SHW; g++) begin : g_stage
    rshift_stage #(.STEP(g)) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_valid    (w_v[g]),
      .i_data     (w_d[g]),
      .i_shift    (w_sh[g]),
      .i_arith    (w_ar[g]),
      .i_sgn      (w_sgn[g]),
      .i_rdy_next (w_rdy[g+1]),
      .o_valid    (w_v[g+1]),
      .o_data     (w_d[g+1]),
      .o_shift    (w_sh[g+1]),
      .o_arith    (w_ar[g+1]),
      .o_sgn      (w_sgn[g+1])
    );
  end

  assign in_ready  = w_rdy[0];
  assign out_valid = w_v[SHW];
  assign out_data  = w_d[SHW];

  logic w_unused;
  assign w_unused = ^{w_sh[SHW], w_ar[SHW], w_sgn[SHW]};

endmodule

// File: doc/rshift_pipe.md
Name: rshift_pipe

Overview:
- Pipelined 64-bit right shifter with valid/ready handshakes on both sides.
- Supports logical (zero-fill) and arithmetic (sign-fill) shifts.
- Complements the combinational left barrel shifter in the MDCLCG datapath, where it extracts high-order bits of LCG state/products (e.g. state >> k for output tempering).
- One log-stage per register stage, so timing closes at full clock rate.

Parameters:
- DATA_W, 64, data width; fixed at 64 for this revision.
- SHW, 6, shift-amount width; equals log2(DATA_W). Also the pipeline depth.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, upstream word is present.
- in_ready, output, 1, block accepts the word this cycle.
- in_data, input, 64, operand.
- in_shift, input, 6, right-shift amount, 0..63.
- in_arith, input, 1, 1 = arithmetic shift (fill with in_data[63]); 0 = logical shift (fill with 0).
- out_valid, output, 1, result is present.
- out_ready, input, 1, downstream accepts the result.
- out_data, output, 64, shifted result.

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n.
- Reset while rst_n=0 at a clk edge:
  - All stage valid bits clear to 0; out_valid=0.
  - All stage data, shift and arith registers clear to 0; out_data=64'h0.
  - in_ready=1 on the first cycle after reset deasserts.
  - Reset mid-operation discards every in-flight word. No partial output appears.
- Pipeline: 6 register stages S0..S5. Each stage k holds v[k], d[k], sh[k] (remaining shift bits), ar[k] and sgn[k] (original bit 63).
- Transfer rule: a word enters stage k when the previous stage (or the input) offers it and rdy[k] is 1.
  - rdy[k] = !v[k] | rdy[k+1].
  - rdy[6] = out_ready.
  - in_ready = rdy[0].
  - These ready terms are combinational, per stage, so bubbles collapse.
- Stage k function: if the shift bit for position k is 1, d[k] = prev >> 2^k with the top 2^k bits filled with (ar & sgn); otherwise d[k] = prev.
  - Order is LSB first: stage 0 handles the 1-bit shift, stage 5 the 32-bit shift.
  - sgn is captured from in_data[63] at S0 and carried forward unchanged, so fill is correct after multiple stages.
- Latency: exactly 6 cycles from acceptance (in_valid & in_ready) to out_valid, when out_ready is held high.
- Throughput: 1 word per cycle sustained when out_ready=1.
- Outputs: out_valid = v[5]; out_data = d[5].
- Stall: while out_valid=1 and out_ready=0, out_data stays stable and every stage is frozen.
  - Exception: empty stages behind a full stage may still fill (bubble collapse).
  - No word is dropped or duplicated.
- Simultaneous events: when S5 drains and S4 advances in the same cycle, S5 loads the new word; throughput is not lost.
- Boundaries:
  - shift=0 passes data unchanged.
  - shift=63 logical gives 0 or 1.
  - shift=63 arithmetic gives all-0 or all-1 depending on in_data[63].
  - in_arith is ignored for words with bit 63 = 0.
- Ordering: strict FIFO order; results carry no tag.
- in_data, in_shift and in_arith are sampled only on an accept cycle. Values offered while in_ready=0 are ignored.

Decomposition:
- Package mdclcg_pkg: DATA_W=64, SHW=6, and the type word_t = logic [63:0].
- Sub-module rshift_stage, parameterised by STEP (0..5). It contains one register stage: valid/data/shift/arith/sgn registers, its rdy term, and the conditional shift by 2**STEP with sign/zero fill.
- rshift_pipe instantiates rshift_stage six times in a generate loop and wires the rdy chain.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 → out_valid=0, out_data=0. One cycle after release, in_ready=1.
- Logical: in_data=64'h8000_0000_0000_00F0, shift=4, arith=0, out_ready=1 → after exactly 6 cycles, out_data=64'h0800_0000_0000_000F.
- Arithmetic at the boundaries:
  - in_data=64'h8000_0000_0000_0000, shift=63, arith=1 → 64'hFFFF_FFFF_FFFF_FFFF.
  - Same operand with arith=0 → 64'h1.
  - shift=0 → result equals the operand.
- Back-to-back stream: 100 random (data, shift, arith) triples, one per cycle, out_ready=1 → 100 results in order, each matching the reference model, no gaps after the first.
- Backpressure: fill the pipe, drop out_ready for 10 cycles, then toggle it randomly → out_data stable while stalled, in_ready=0 once all 6 stages are full, every result delivered once, in order.
- Mid-stream reset: assert rst_n=0 with 4 words in flight → none of those words ever appear. A word sent after reset emerges 6 cycles later with the correct value.
